// File: rtl/efuse_ctrl_pkg.sv
// Shared types and sizing for the eFuse sequencer: FSM states, access opcode,
// default geometry and the phase-timer width.
package efuse_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_SETUP     = 3'd1,
        ST_CLK_HI    = 3'd2,
        ST_PGM_PULSE = 3'd3,
        ST_CLK_LO    = 3'd4,
        ST_HOLD      = 3'd5,
        ST_DONE      = 3'd6
    } efuse_state_e;

    typedef enum logic {
        EFUSE_OP_READ = 1'b0,
        EFUSE_OP_PROG = 1'b1
    } efuse_op_e;

    localparam int EFUSE_NBITS        = 32;
    localparam int EFUSE_SCLK_DIV     = 4;
    localparam int EFUSE_SETUP_CYCLES = 2;
    localparam int EFUSE_PGM_CYCLES   = 40;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

    // Wide enough to hold the longest phase length minus one, never zero bits.
    function automatic int tmr_width(input int a, input int b, input int c);
        return $clog2(max3(a, b, c) + 1);
    endfunction

    localparam int EFUSE_TMR_W = tmr_width(EFUSE_SCLK_DIV, EFUSE_SETUP_CYCLES, EFUSE_PGM_CYCLES);

endpackage

// File: rtl/efuse_ctrl_if.sv
// Register-file side of the eFuse sequencer: request inputs and captured-word outputs.
interface efuse_ctrl_if
    import efuse_pkg::*;
#(
    parameter int NBITS = EFUSE_NBITS
) ();
    logic             load_req;
    logic             pgm_req;
    logic             pgm_en;
    logic [NBITS-1:0] pgm_data;
    logic             busy;
    logic             done;
    logic             data_valid;
    logic [NBITS-1:0] efuse_data;
    logic             pgm_err;

    modport master (
        output load_req, pgm_req, pgm_en, pgm_data,
        input  busy, done, data_valid, efuse_data, pgm_err
    );

    modport slave (
        input  load_req, pgm_req, pgm_en, pgm_data,
        output busy, done, data_valid, efuse_data, pgm_err
    );
endinterface

// File: rtl/efuse_ctrl_phase_timer.sv
// Loadable down-counter shared by every timed FSM phase; expires when it reaches zero.
module efuse_phase_timer #(
    parameter int W = 6
) (
    input  logic         clk_osc,
    input  logic         rst_n,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    output logic         o_expire
);
    logic [W-1:0] r_cnt;

    // Reload on phase entry, otherwise count down and park at zero.
    always_ff @(posedge clk_osc or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= {W{1'b0}};
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (r_cnt != {W{1'b0}}) begin
            r_cnt <= r_cnt - {{(W-1){1'b0}}, 1'b1};
        end else begin
            r_cnt <= r_cnt;
        end
    end

    assign o_expire = (r_cnt == {W{1'b0}});
endmodule

// File: rtl/efuse_ctrl.sv
// eFuse sequencer: auto-load after reset, on-demand load, and program with automatic
// readback verification over a serial-in/serial-out fuse macro.
module efuse_ctrl
    import efuse_pkg::*;
#(
    parameter int NBITS        = EFUSE_NBITS,
    parameter int SCLK_DIV     = EFUSE_SCLK_DIV,
    parameter int SETUP_CYCLES = EFUSE_SETUP_CYCLES,
    parameter int PGM_CYCLES   = EFUSE_PGM_CYCLES
) (
    input  logic         clk_osc,
    input  logic         rst_n,
    efuse_ctrl_if.slave  bus,
    output logic         EFUSE_SCLK,
    output logic         EFUSE_CS,
    output logic         EFUSE_RW,
    output logic         EFUSE_PGM,
    input  logic         EFUSE_DOUT
);
    localparam int CNT_W = $clog2(NBITS);
    localparam int TMR_W = tmr_width(SCLK_DIV, SETUP_CYCLES, PGM_CYCLES);

    efuse_state_e     r_state, w_next_state;
    efuse_op_e        r_op, w_next_op;
    logic             r_pending_load, r_readback;
    logic [NBITS-1:0] r_pgm_data, r_shift, r_efuse_data;
    logic [CNT_W-1:0] r_cnt;
    logic             r_busy, r_done, r_data_valid, r_pgm_err;
    logic             r_sclk, r_cs, r_rw, r_pgm;
    logic             w_accept_read, w_accept_prog, w_sample, w_cnt_inc, w_to_readback;
    logic             w_tmr_load, w_tmr_expire;
    logic [TMR_W-1:0] w_tmr_val;
    logic             w_cs, w_sclk;

    function automatic logic [TMR_W-1:0] phase_len_m1(input efuse_state_e st);
        case (st)
            ST_SETUP, ST_HOLD:    phase_len_m1 = TMR_W'(SETUP_CYCLES - 1);
            ST_CLK_HI, ST_CLK_LO: phase_len_m1 = TMR_W'(SCLK_DIV - 1);
            ST_PGM_PULSE:         phase_len_m1 = TMR_W'(PGM_CYCLES - 1);
            default:              phase_len_m1 = {TMR_W{1'b0}};
        endcase
    endfunction

    efuse_phase_timer #(.W(TMR_W)) u_timer (
        .clk_osc    (clk_osc),
        .rst_n      (rst_n),
        .i_load     (w_tmr_load),
        .i_load_val (w_tmr_val),
        .o_expire   (w_tmr_expire)
    );

    // Next-state, next-op and per-transition strobes.
    always_comb begin
        w_next_state  = r_state;
        w_next_op     = r_op;
        w_accept_read = 1'b0;
        w_accept_prog = 1'b0;
        w_sample      = 1'b0;
        w_cnt_inc     = 1'b0;
        w_to_readback = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (r_pending_load || bus.load_req) begin
                    w_accept_read = 1'b1;
                    w_next_op     = EFUSE_OP_READ;
                    w_next_state  = ST_SETUP;
                end else if (bus.pgm_req && bus.pgm_en) begin
                    w_accept_prog = 1'b1;
                    w_next_op     = EFUSE_OP_PROG;
                    w_next_state  = ST_SETUP;
                end else begin
                    w_next_state  = ST_IDLE;
                end
            end
            ST_SETUP: begin
                if (w_tmr_expire) w_next_state = ST_CLK_HI;
                else              w_next_state = ST_SETUP;
            end
            ST_CLK_HI: begin
                if (!w_tmr_expire) begin
                    w_next_state = ST_CLK_HI;
                end else if (r_op == EFUSE_OP_PROG && r_pgm_data[r_cnt]) begin
                    w_next_state = ST_PGM_PULSE;
                end else begin
                    w_sample     = (r_op == EFUSE_OP_READ);
                    w_next_state = ST_CLK_LO;
                end
            end
            ST_PGM_PULSE: begin
                if (w_tmr_expire) w_next_state = ST_CLK_LO;
                else              w_next_state = ST_PGM_PULSE;
            end
            ST_CLK_LO: begin
                if (!w_tmr_expire) begin
                    w_next_state = ST_CLK_LO;
                end else if (r_cnt == CNT_W'(NBITS - 1)) begin
                    w_next_state = ST_HOLD;
                end else begin
                    w_cnt_inc    = 1'b1;
                    w_next_state = ST_CLK_HI;
                end
            end
            ST_HOLD: begin
                if (!w_tmr_expire) begin
                    w_next_state = ST_HOLD;
                end else if (r_op == EFUSE_OP_PROG) begin
                    w_to_readback = 1'b1;
                    w_next_op     = EFUSE_OP_READ;
                    w_next_state  = ST_SETUP;
                end else begin
                    w_next_state  = ST_DONE;
                end
            end
            ST_DONE: w_next_state = ST_IDLE;
            default: w_next_state = ST_IDLE;
        endcase
    end

    assign w_tmr_load = (w_next_state != r_state);
    assign w_tmr_val  = phase_len_m1(w_next_state);
    assign w_cs       = (w_next_state == ST_SETUP) || (w_next_state == ST_CLK_HI) ||
                        (w_next_state == ST_PGM_PULSE) || (w_next_state == ST_CLK_LO);
    assign w_sclk     = (w_next_state == ST_CLK_HI) || (w_next_state == ST_PGM_PULSE);

    // State, datapath and pin registers; pins are registered from the next state.
    always_ff @(posedge clk_osc or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= ST_IDLE;
            r_op           <= EFUSE_OP_READ;
            r_pending_load <= 1'b1;
            r_readback     <= 1'b0;
            r_pgm_data     <= {NBITS{1'b0}};
            r_shift        <= {NBITS{1'b0}};
            r_efuse_data   <= {NBITS{1'b0}};
            r_cnt          <= {CNT_W{1'b0}};
            r_busy         <= 1'b0;
            r_done         <= 1'b0;
            r_data_valid   <= 1'b0;
            r_pgm_err      <= 1'b0;
            r_sclk         <= 1'b0;
            r_cs           <= 1'b0;
            r_rw           <= 1'b0;
            r_pgm          <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_op    <= w_next_op;
            r_busy  <= (w_next_state != ST_IDLE);
            r_done  <= (w_next_state == ST_DONE);
            r_cs    <= w_cs;
            r_rw    <= w_cs && (w_next_op == EFUSE_OP_PROG);
            r_sclk  <= w_sclk;
            r_pgm   <= (w_next_state == ST_PGM_PULSE);
            if (w_accept_read) r_pending_load <= 1'b0;
            if (w_accept_prog) begin
                r_pgm_data <= bus.pgm_data;
                r_pgm_err  <= 1'b0;
            end
            if (w_to_readback)           r_readback <= 1'b1;
            else if (r_state == ST_DONE) r_readback <= 1'b0;
            if (w_next_state == ST_SETUP) begin
                r_cnt   <= {CNT_W{1'b0}};
                r_shift <= (r_state == ST_SETUP) ? r_shift : {NBITS{1'b0}};
            end else begin
                if (w_cnt_inc) r_cnt <= r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
                if (w_sample)  r_shift[r_cnt] <= EFUSE_DOUT;
            end
            // Captured word and readback verdict are published together.
            if (w_next_state == ST_DONE) begin
                r_efuse_data <= r_shift;
                r_data_valid <= 1'b1;
                if (r_readback) r_pgm_err <= |(r_pgm_data & ~r_shift);
            end
        end
    end

    assign bus.busy       = r_busy;
    assign bus.done       = r_done;
    assign bus.data_valid = r_data_valid;
    assign bus.efuse_data = r_efuse_data;
    assign bus.pgm_err    = r_pgm_err;
    assign EFUSE_SCLK     = r_sclk;
    assign EFUSE_CS       = r_cs;
    assign EFUSE_RW       = r_rw;
    assign EFUSE_PGM      = r_pgm;
endmodule
